// File: rtl/jtpopeye_obj_dma.sv
// Popeye object DMA: on each VB rise, borrows the Z80 bus, copies LEN bytes
// from main RAM (0x8C00 window) into the object-line RAM, then releases the bus.
// Optional macro JTPOPEYE_DMA_TIMEOUT_EN: abandon a bus request that is not
// granted within TIMEOUT cen ticks and raise the sticky aborted flag.
`timescale 1ns/1ps

module jtpopeye_obj_dma #(
    parameter int unsigned LEN     = 1024,
    parameter int unsigned RDLAT   = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        VB,
    output logic        busrq_n,
    input  logic        busak_n,
    output logic        dma_cs,
    output logic [9:0]  dma_addr,
    input  logic [7:0]  dma_din,
    output logic [9:0]  obj_addr,
    output logic [7:0]  obj_data,
    output logic        obj_we,
    output logic        busy,
    output logic        done,
    output logic        aborted
);

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = $clog2(LEN + 1);

    // Reject parameter values the address/pipeline logic cannot honour
    if (LEN < 1 || LEN > 1024 || RDLAT < 1 || RDLAT > 3 || TIMEOUT < 1) begin : g_param_check
        $error("jtpopeye_obj_dma: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_FLUSH,
        S_REL
    } state_t;

    state_t                   state_q, state_d;
    logic                     vbl_q, vbl_d;
    logic                     busrq_n_q, busrq_n_d;
    logic                     dma_cs_q, dma_cs_d;
    logic [AW-1:0]            dma_addr_q, dma_addr_d;
    logic [AW-1:0]            obj_addr_q, obj_addr_d;
    logic [DW-1:0]            obj_data_q, obj_data_d;
    logic                     obj_we_q, obj_we_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [CW-1:0]            issue_q, issue_d;
    logic [RDLAT-1:0]         vld_q, vld_d;
    logic [RDLAT-1:0][AW-1:0] apipe_q, apipe_d;
    logic                     push;
    logic                     drop_pipe;

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          aborted_q, aborted_d;
`endif

    // Next-state, address issue and read-data capture
    always_comb begin
        state_d    = state_q;
        vbl_d      = vbl_q;
        busrq_n_d  = busrq_n_q;
        dma_cs_d   = dma_cs_q;
        dma_addr_d = dma_addr_q;
        obj_addr_d = obj_addr_q;
        obj_data_d = obj_data_q;
        obj_we_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        issue_d    = issue_q;
        vld_d      = vld_q;
        apipe_d    = apipe_q;
        push       = 1'b0;
        drop_pipe  = 1'b0;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        aborted_d  = aborted_q;
`endif

        if (cen) begin
            vbl_d = VB;
            unique case (state_q)
                S_IDLE: begin
                    if (VB && !vbl_q) begin
                        state_d   = S_REQ;
                        busrq_n_d = 1'b0;
                        busy_d    = 1'b1;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
                        to_cnt_d  = '0;
`endif
                    end
                end
                S_REQ: begin
                    if (!busak_n) begin
                        dma_cs_d   = 1'b1;
                        dma_addr_d = '0;
                        issue_d    = CW'(1);
                        push       = 1'b1;
                        state_d    = (LEN == 1) ? S_FLUSH : S_XFER;
                    end
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
                    else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                        state_d   = S_IDLE;
                        busrq_n_d = 1'b1;
                        busy_d    = 1'b0;
                        aborted_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TW'(1);
                    end
`endif
                end
                S_XFER, S_FLUSH: begin
                    if (busak_n) begin
                        // Bus taken back mid-transfer: drop in-flight reads
                        drop_pipe = 1'b1;
                        state_d   = S_REL;
                        dma_cs_d  = 1'b0;
                        busrq_n_d = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        if (vld_q[RDLAT-1]) begin
                            obj_we_d   = 1'b1;
                            obj_addr_d = apipe_q[RDLAT-1];
                            obj_data_d = dma_din;
                        end
                        if (state_q == S_XFER) begin
                            if (issue_q < CW'(LEN)) begin
                                dma_addr_d = dma_addr_q + AW'(1);
                                issue_d    = issue_q + CW'(1);
                                push       = 1'b1;
                                if (issue_q == CW'(LEN - 1)) begin
                                    state_d = S_FLUSH;
                                end
                            end
                        end else if (vld_q == '0) begin
                            // Last byte was written on an earlier tick
                            state_d   = S_REL;
                            dma_cs_d  = 1'b0;
                            busrq_n_d = 1'b1;
                            done_d    = 1'b1;
                        end
                    end
                end
                S_REL: begin
                    if (busak_n) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (drop_pipe) begin
                vld_d = '0;
            end else begin
                vld_d[0]   = push;
                apipe_d[0] = dma_addr_d;
                for (int unsigned i = 1; i < RDLAT; i++) begin
                    vld_d[i]   = vld_q[i-1];
                    apipe_d[i] = apipe_q[i-1];
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            vbl_q      <= 1'b0;
            busrq_n_q  <= 1'b1;
            dma_cs_q   <= 1'b0;
            dma_addr_q <= '0;
            obj_addr_q <= '0;
            obj_data_q <= '0;
            obj_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            issue_q    <= '0;
            vld_q      <= '0;
            apipe_q    <= '0;
        end else begin
            state_q    <= state_d;
            vbl_q      <= vbl_d;
            busrq_n_q  <= busrq_n_d;
            dma_cs_q   <= dma_cs_d;
            dma_addr_q <= dma_addr_d;
            obj_addr_q <= obj_addr_d;
            obj_data_q <= obj_data_d;
            obj_we_q   <= obj_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            issue_q    <= issue_d;
            vld_q      <= vld_d;
            apipe_q    <= apipe_d;
        end
    end

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
    // Grant-timeout counter and sticky abort flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            aborted_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            aborted_q <= aborted_d;
        end
    end
    assign aborted = aborted_q;
`else
    assign aborted = 1'b0;
`endif

    assign busrq_n  = busrq_n_q;
    assign dma_cs   = dma_cs_q;
    assign dma_addr = dma_addr_q;
    assign obj_addr = obj_addr_q;
    assign obj_data = obj_data_q;
    assign obj_we   = obj_we_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_jtpopeye_obj_dma.sv
// Bench for jtpopeye_obj_dma: a full-size instance (LEN 1024, RDLAT 2) and a
// short instance (LEN 4, RDLAT 1), with bus-grant and main-RAM models.
`timescale 1ns/1ps

module tb_jtpopeye_obj_dma;

    localparam int unsigned LEN_A = 1024;
    localparam int unsigned LEN_B = 4;
    localparam int unsigned TMO   = 8;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct packed {
        logic [3:0]      dly;
        logic [7:0]      key;
        logic [3:0][7:0] exp;
    } vec_t;

    logic       clk, rst_n, cen;
    logic       vb_a, busrq_n_a, busak_n_a, dma_cs_a, obj_we_a, busy_a, done_a, aborted_a;
    logic [9:0] dma_addr_a, obj_addr_a;
    logic [7:0] dma_din_a, obj_data_a;
    logic       vb_b, busrq_n_b, busak_n_b, dma_cs_b, obj_we_b, busy_b, done_b, aborted_b;
    logic [9:0] dma_addr_b, obj_addr_b;
    logic [7:0] dma_din_b, obj_data_b, key_b;

    int   tests, fails;
    int   we_a, we_b, done_a_cnt, done_b_cnt;
    wr_t  qa[$], qb[$];
    int   grant_dly_a, grant_dly_b, gcnt_a, gcnt_b;
    bit   cpu_drop, cpu_hold;
    logic [9:0] last_addr_a;
    vec_t vecs [4];

    jtpopeye_obj_dma #(.LEN(LEN_A), .RDLAT(2), .TIMEOUT(TMO)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cen(cen), .VB(vb_a),
        .busrq_n(busrq_n_a), .busak_n(busak_n_a), .dma_cs(dma_cs_a),
        .dma_addr(dma_addr_a), .dma_din(dma_din_a), .obj_addr(obj_addr_a),
        .obj_data(obj_data_a), .obj_we(obj_we_a), .busy(busy_a),
        .done(done_a), .aborted(aborted_a)
    );

    jtpopeye_obj_dma #(.LEN(LEN_B), .RDLAT(1), .TIMEOUT(TMO)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cen(cen), .VB(vb_b),
        .busrq_n(busrq_n_b), .busak_n(busak_n_b), .dma_cs(dma_cs_b),
        .dma_addr(dma_addr_b), .dma_din(dma_din_b), .obj_addr(obj_addr_b),
        .obj_data(obj_data_b), .obj_we(obj_we_b), .busy(busy_b),
        .done(done_b), .aborted(aborted_b)
    );

    // Zero-latency RAM behind the short instance
    assign dma_din_b = dma_addr_b[7:0] ^ key_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cen is high on every other clock edge
    initial begin
        cen = 1'b0;
        forever begin
            @(negedge clk);
            cen = ~cen;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        do begin
            @(posedge clk);
            #2;
        end while (!cen);
    endtask

    // CPU bus-grant and registered main-RAM models, updated after each cen tick
    initial begin
        busak_n_a = 1'b1;
        busak_n_b = 1'b1;
        dma_din_a = 8'h00;
        last_addr_a = '0;
        gcnt_a = 0;
        gcnt_b = 0;
        forever begin
            @(posedge clk);
            #1;
            if (cen) begin
                if (busrq_n_a || cpu_drop || cpu_hold) begin
                    busak_n_a = 1'b1;
                    gcnt_a = 0;
                end else if (busak_n_a) begin
                    gcnt_a++;
                    if (gcnt_a >= grant_dly_a) busak_n_a = 1'b0;
                end
                if (busrq_n_b) begin
                    busak_n_b = 1'b1;
                    gcnt_b = 0;
                end else if (busak_n_b) begin
                    gcnt_b++;
                    if (gcnt_b >= grant_dly_b) busak_n_b = 1'b0;
                end
                dma_din_a   = last_addr_a[7:0] ^ 8'h5A;
                last_addr_a = dma_addr_a;
            end
        end
    end

    // Scoreboard for the full-size instance
    always @(posedge clk) begin
        #1;
        if (obj_we_a) begin
            we_a++;
            if (qa.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL a_spurious_write: addr %0d data 0x%0h with no write pending", obj_addr_a, obj_data_a);
            end else begin
                chk("a_write", 32'({obj_addr_a, obj_data_a}), 32'(qa.pop_front()));
            end
        end
        if (done_a) begin
            done_a_cnt++;
            chk("a_done_excl_we", 32'(obj_we_a), 32'd0);
        end
    end

    // Scoreboard for the short instance
    always @(posedge clk) begin
        #1;
        if (obj_we_b) begin
            we_b++;
            if (qb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_spurious_write: addr %0d data 0x%0h with no write pending", obj_addr_b, obj_data_b);
            end else begin
                chk("b_write", 32'({obj_addr_b, obj_data_b}), 32'(qb.pop_front()));
            end
        end
        if (done_b) begin
            done_b_cnt++;
            chk("b_done_excl_we", 32'(obj_we_b), 32'd0);
        end
    end

    task automatic push_full_a();
        for (int i = 0; i < int'(LEN_A); i++) begin
            qa.push_back(wr_t'{addr: 10'(i), data: 8'(i) ^ 8'h5A});
        end
    endtask

    // One complete transfer on instance A, optionally re-pulsing VB at byte retrig_at
    task automatic run_a(input string name, input int retrig_at);
        int base, dbase, n, rt, rtc;
        base  = we_a;
        dbase = done_a_cnt;
        n = 0; rt = 0; rtc = 0;
        push_full_a();
        vb_a = 1'b1;
        while (done_a_cnt == dbase && n < 5000) begin
            tick();
            n++;
            if (retrig_at > 0) begin
                if (rt == 0 && we_a - base >= retrig_at) begin
                    vb_a = 1'b0;
                    rt = 1;
                end else if (rt == 1) begin
                    rtc++;
                    if (rtc == 2) begin
                        vb_a = 1'b1;
                        rt = 2;
                    end
                end
            end
        end
        chk({name, "_done"}, 32'(done_a_cnt - dbase), 32'd1);
        chk({name, "_writes"}, 32'(we_a - base), 32'(LEN_A));
        chk({name, "_queue_empty"}, 32'(qa.size()), 32'd0);
        chk({name, "_busrq_rel"}, 32'(busrq_n_a), 32'd1);
        chk({name, "_cs_rel"}, 32'(dma_cs_a), 32'd0);
        qa.delete();
        repeat (6) tick();
        chk({name, "_idle_busy"}, 32'(busy_a), 32'd0);
        chk({name, "_idle_busrq"}, 32'(busrq_n_a), 32'd1);
        chk({name, "_single_done"}, 32'(done_a_cnt - dbase), 32'd1);
        vb_a = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        int base, dbase, n, k, wb;
        tests = 0; fails = 0;
        we_a = 0; we_b = 0; done_a_cnt = 0; done_b_cnt = 0;
        grant_dly_a = 3; grant_dly_b = 3;
        cpu_drop = 1'b0; cpu_hold = 1'b0;
        rst_n = 1'b0; vb_a = 1'b0; vb_b = 1'b0; key_b = 8'h5A;

        vecs[0] = '{dly: 4'd3, key: 8'h5A, exp: {8'h59, 8'h58, 8'h5B, 8'h5A}};
        vecs[1] = '{dly: 4'd1, key: 8'h00, exp: {8'h03, 8'h02, 8'h01, 8'h00}};
        vecs[2] = '{dly: 4'd5, key: 8'hFF, exp: {8'hFC, 8'hFD, 8'hFE, 8'hFF}};
        vecs[3] = '{dly: 4'd2, key: 8'hA5, exp: {8'hA6, 8'hA7, 8'hA4, 8'hA5}};

        repeat (4) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_busrq_n", 32'(busrq_n_a), 32'd1);
        chk("rst_dma_cs", 32'(dma_cs_a), 32'd0);
        chk("rst_dma_addr", 32'(dma_addr_a), 32'd0);
        chk("rst_obj", 32'({obj_addr_a, obj_data_a, obj_we_a}), 32'd0);
        chk("rst_busy_done", 32'({busy_a, done_a}), 32'd0);
        chk("rst_aborted", 32'(aborted_a), 32'd0);

        // Plain full transfer
        run_a("t1", 0);

        // VB re-pulsed mid-transfer is ignored, a later rise starts afresh
        run_a("t3", 300);
        run_a("t3_next", 0);

        // Asynchronous reset in the middle of a transfer
        base = we_a;
        push_full_a();
        vb_a = 1'b1;
        n = 0;
        while (we_a - base < 500 && n < 3000) begin
            tick();
            n++;
        end
        chk("t4_reached_500", 32'(we_a - base >= 500), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_busrq_n", 32'(busrq_n_a), 32'd1);
        chk("t4_rst_dma_cs", 32'(dma_cs_a), 32'd0);
        chk("t4_rst_obj_we", 32'(obj_we_a), 32'd0);
        chk("t4_rst_busy", 32'(busy_a), 32'd0);
        qa.delete();
        vb_a = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        wb = we_a;
        repeat (8) tick();
        chk("t4_idle_busrq", 32'(busrq_n_a), 32'd1);
        chk("t4_idle_no_write", 32'(we_a - wb), 32'd0);
        run_a("t4_restart", 0);

        // CPU takes the bus back at byte 100
        base = we_a;
        dbase = done_a_cnt;
        push_full_a();
        vb_a = 1'b1;
        n = 0;
        while (we_a - base < 100 && n < 3000) begin
            tick();
            n++;
        end
        cpu_drop = 1'b1;
        n = 0;
        while (done_a_cnt == dbase && n < 50) begin
            tick();
            n++;
        end
        k = we_a - base;
        chk("t5_done", 32'(done_a_cnt - dbase), 32'd1);
        chk("t5_truncated", 32'(k >= 100 && k <= 104), 32'd1);
        chk("t5_busrq_rel", 32'(busrq_n_a), 32'd1);
        chk("t5_cs_rel", 32'(dma_cs_a), 32'd0);
        qa.delete();
        wb = we_a;
        repeat (8) tick();
        chk("t5_no_late_write", 32'(we_a - wb), 32'd0);
        chk("t5_idle_busy", 32'(busy_a), 32'd0);
        cpu_drop = 1'b0;
        vb_a = 1'b0;
        repeat (2) tick();

        // Short instance, table of grant delays and RAM contents
        for (int i = 0; i < 4; i++) begin
            key_b = vecs[i].key;
            grant_dly_b = int'(vecs[i].dly);
            for (int j = 0; j < int'(LEN_B); j++) begin
                qb.push_back(wr_t'{addr: 10'(j), data: vecs[i].exp[j]});
            end
            base = we_b;
            dbase = done_b_cnt;
            vb_b = 1'b1;
            n = 0;
            while (done_b_cnt == dbase && n < 200) begin
                tick();
                n++;
            end
            chk("b_done", 32'(done_b_cnt - dbase), 32'd1);
            chk("b_writes", 32'(we_b - base), 32'(LEN_B));
            chk("b_queue_empty", 32'(qb.size()), 32'd0);
            chk("b_busy_at_release", 32'({busak_n_b, busy_b}), 32'b11);
            tick();
            chk("b_busy_fall", 32'(busy_b), 32'd0);
            qb.delete();
            vb_b = 1'b0;
            repeat (2) tick();
        end

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
        // Grant never arrives: request is withdrawn after TMO ticks
        base = we_a;
        dbase = done_a_cnt;
        cpu_hold = 1'b1;
        vb_a = 1'b1;
        n = 0;
        while (busrq_n_a && n < 20) begin
            tick();
            n++;
        end
        n = 0;
        while (!busrq_n_a && n < 50) begin
            tick();
            n++;
        end
        chk("t6_timeout_ticks", 32'(n), 32'(TMO));
        chk("t6_aborted", 32'(aborted_a), 32'd1);
        chk("t6_busy", 32'(busy_a), 32'd0);
        repeat (4) tick();
        chk("t6_no_done", 32'(done_a_cnt - dbase), 32'd0);
        chk("t6_no_write", 32'(we_a - base), 32'd0);
        chk("t6_aborted_sticky", 32'(aborted_a), 32'd1);
        cpu_hold = 1'b0;
        vb_a = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_aborted_reset", 32'(aborted_a), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();
`else
        chk("aborted_tied_low", 32'({aborted_a, aborted_b}), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
